// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the fetch sequencer.
//   fetch_state_e : fetch FSM encoding (IDLE / REQ / HOLD)
//   STALL_*       : per-stage stall patterns, bit [0]=PC .. [5]=WB
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // out of reset, nothing issued yet
    REQ  = 2'd1,  // one fetch outstanding on the imem port
    HOLD = 2'd2   // fetched instruction parked while IF is stalled
  } fetch_state_e;

  localparam int STALL_W = 6;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;  // fetch bubble
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: pair of saturating 32-bit event counters.
// Only compiled when FETCH_PERF_EN is defined; otherwise this file is empty.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   wait_inc_i        : count one fetch-wait cycle
//   redir_inc_i       : count one redirect event
//   wait_cnt_o        : fetch-wait cycle count
//   redir_cnt_o       : redirect event count
`ifdef FETCH_PERF_EN
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        wait_inc_i,
  input  logic        redir_inc_i,
  output logic [31:0] wait_cnt_o,
  output logic [31:0] redir_cnt_o
);

  logic [31:0] wait_q, wait_d;
  logic [31:0] redir_q, redir_d;

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    wait_d  = wait_q;
    redir_d = redir_q;
    if (wait_inc_i  && (wait_q  != 32'hFFFF_FFFF)) wait_d  = wait_q  + 32'd1;
    if (redir_inc_i && (redir_q != 32'hFFFF_FFFF)) redir_d = redir_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q  <= '0;
      redir_q <= '0;
    end else begin
      wait_q  <= wait_d;
      redir_q <= redir_d;
    end
  end

  assign wait_cnt_o  = wait_q;
  assign redir_cnt_o = redir_q;

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer and stall controller.
// Owns the PC, runs a single-outstanding req/ack imem port, resolves
// flush / delay-slot branch redirects and stage stall requests into the
// per-stage stall vector and the IF/ID output registers.
// Ports:
//   clk, rst                    : clock, synchronous active-low reset
//   stall_req_id/_ex            : decode / execute stall requests
//   branch_flag, branch_target  : taken branch from ID (delay slot semantics)
//   flush, new_pc               : exception redirect, highest priority
//   imem_req/addr (out), imem_ack/rdata (in) : instruction memory port
//   if_valid, if_pc, if_inst    : IF/ID register outputs
//   stall[5:0]                  : PC,IF,ID,EX,MEM,WB stall, combinational
// Optional: FETCH_PERF_EN adds perf_wait_cnt / perf_redir_cnt.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req_id,
  input  logic              stall_req_ex,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_inst,
  output logic [5:0]        stall
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_wait_cnt,
  output logic [31:0]       perf_redir_cnt
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       buf_q, buf_d;
  logic              req_q, req_d;
  logic              if_valid_q, if_valid_d;
  logic              discard_q, discard_d;
  logic              tgt_pend_q, tgt_pend_d;

  logic              ack_v;
  logic              if_hold;
  logic [ADDR_W-1:0] nxt_pc;

  // An ack only counts against a live request; acks seen in IDLE (e.g.
  // left over from a request abandoned by reset) are ignored.
  assign ack_v   = (state_q == REQ) && req_q && imem_ack;
  // IF is held only by downstream stall requests; a fetch bubble alone
  // lets IF drain to an invalid slot.
  assign if_hold = !flush && (stall_req_ex || stall_req_id);
  // Address following a completed delay slot. A branch arriving the same
  // cycle the delay slot completes redirects immediately.
  assign nxt_pc  = (branch_flag && !flush) ? branch_target :
                   tgt_pend_q              ? target_q      :
                                             pc_q + ADDR_W'(4);

  always_comb begin
    if (flush)                                stall = STALL_NONE;
    else if (stall_req_ex)                    stall = STALL_EX;
    else if (stall_req_id)                    stall = STALL_ID;
    else if ((state_q == REQ) && !ack_v)      stall = STALL_IF;
    else                                      stall = STALL_NONE;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    target_d   = target_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    buf_d      = buf_q;
    req_d      = req_q;
    if_valid_d = if_valid_q;
    discard_d  = discard_q;
    tgt_pend_d = tgt_pend_q;

    if (branch_flag && !flush) begin
      target_d   = branch_target;
      tgt_pend_d = 1'b1;
    end

    if (flush) begin
      if_valid_d = 1'b0;
      pc_d       = new_pc;
      tgt_pend_d = 1'b0;
      if ((state_q == REQ) && !ack_v) begin
        // Old request still in flight: keep addr stable, eat its ack.
        discard_d = 1'b1;
      end else begin
        state_d   = REQ;
        req_d     = 1'b1;
        addr_d    = new_pc;
        discard_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc_q;
          if (!if_hold) if_valid_d = 1'b0;
        end
        REQ: begin
          if (ack_v) begin
            if (discard_q) begin
              // pc_q already holds the flush target.
              discard_d = 1'b0;
              addr_d    = pc_q;
              if (!if_hold) if_valid_d = 1'b0;
            end else if (if_hold) begin
              buf_d   = imem_rdata;
              req_d   = 1'b0;
              state_d = HOLD;
            end else begin
              if_valid_d = 1'b1;
              if_inst_d  = imem_rdata;
              if_pc_d    = addr_q;
              pc_d       = nxt_pc;
              addr_d     = nxt_pc;
              tgt_pend_d = 1'b0;
            end
          end else if (!if_hold) begin
            if_valid_d = 1'b0;
          end
        end
        HOLD: begin
          // addr_q still holds the buffered instruction's address.
          if (!if_hold) begin
            if_valid_d = 1'b1;
            if_inst_d  = buf_q;
            if_pc_d    = addr_q;
            pc_d       = nxt_pc;
            addr_d     = nxt_pc;
            tgt_pend_d = 1'b0;
            req_d      = 1'b1;
            state_d    = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= '0;
      target_q   <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      buf_q      <= '0;
      req_q      <= 1'b0;
      if_valid_q <= 1'b0;
      discard_q  <= 1'b0;
      tgt_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      target_q   <= target_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      buf_q      <= buf_d;
      req_q      <= req_d;
      if_valid_q <= if_valid_d;
      discard_q  <= discard_d;
      tgt_pend_q <= tgt_pend_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;

`ifdef FETCH_PERF_EN
  fetch_perf_cnt u_perf (
    .clk         (clk),
    .rst         (rst),
    .wait_inc_i  ((state_q == REQ) && !ack_v),
    .redir_inc_i (flush || branch_flag),
    .wait_cnt_o  (perf_wait_cnt),
    .redir_cnt_o (perf_redir_cnt)
  );
`endif

endmodule
